// File: rtl/hdmi_mem_pkg.sv
// rtl/hdmi_mem_pkg.sv - shared widths and port tag type for the on-chip pattern memory
package hdmi_mem_pkg;

    localparam int MEM_AW  = 11;
    localparam int MEM_DW  = 256;
    localparam int MEM_BEW = MEM_DW / 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
    } rd_tag_t;

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// rtl/mem_rd_tag_pipe.sv - {valid, port} delay line that follows each read through the RAM
module mem_rd_tag_pipe
    import hdmi_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_port,
    output logic out_valid,
    output logic out_port
);

    rd_tag_t stage [DEPTH];

    // Shift one tag per cycle; writes and idle cycles travel as invalid bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= '{valid: in_valid, port: port_e'(in_port)};
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i - 1];
            end
        end
    end

    assign out_valid = stage[DEPTH - 1].valid;
    assign out_port  = stage[DEPTH - 1].port;

endmodule

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - fixed-priority A/B arbiter with starvation guard for the pattern RAM
module onchip_mem_arbiter
    import hdmi_mem_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MAX_A_RUN    = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 a_req,
    input  logic [MEM_AW-1:0]    a_addr,
    output logic                 a_ready,
    output logic                 a_rvalid,
    output logic [MEM_DW-1:0]    a_rdata,

    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [MEM_AW-1:0]    b_addr,
    input  logic [MEM_BEW-1:0]   b_be,
    input  logic [MEM_DW-1:0]    b_wdata,
    output logic                 b_ready,
    output logic                 b_rvalid,
    output logic [MEM_DW-1:0]    b_rdata,

    output logic                 onchip_mem_chip_select,
    output logic                 onchip_mem_chip_read,
    output logic                 onchip_mem_write,
    output logic [MEM_AW-1:0]    onchip_mem_addr,
    output logic [MEM_BEW-1:0]   onchip_mem_byte_enable,
    output logic [MEM_DW-1:0]    onchip_mem_write_data,
    input  logic [MEM_DW-1:0]    onchip_mem_readd_data
);

    localparam logic [7:0] RUN_LIMIT = 8'(MAX_A_RUN);

    logic [7:0] a_run;
    logic       grant_a;
    logic       grant_b;
    logic       issue_read;
    logic       issue_port;
    logic       ret_valid;
    logic       ret_port;

    // Grant: A wins ties unless it has already used its run while B waited
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (a_req && b_req) begin
                if (a_run == RUN_LIMIT) begin
                    grant_b = 1'b1;
                end else begin
                    grant_a = 1'b1;
                end
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign issue_read = grant_a | (grant_b & ~b_we);
    assign issue_port = grant_b ? PORT_B : PORT_A;

    // Count A grants that B had to watch; any B grant or B going quiet starts over
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_run <= 8'd0;
        end else if (!b_req || grant_b) begin
            a_run <= 8'd0;
        end else if (grant_a && (a_run != RUN_LIMIT)) begin
            a_run <= a_run + 8'd1;
        end
    end

    // Register the winning command onto the memory bus; address/data hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            onchip_mem_chip_select <= 1'b0;
            onchip_mem_chip_read   <= 1'b0;
            onchip_mem_write       <= 1'b0;
            onchip_mem_addr        <= '0;
            onchip_mem_byte_enable <= '0;
            onchip_mem_write_data  <= '0;
        end else begin
            onchip_mem_chip_select <= grant_a | grant_b;
            onchip_mem_chip_read   <= issue_read;
            onchip_mem_write       <= grant_b & b_we;
            if (grant_a) begin
                onchip_mem_addr        <= a_addr;
                onchip_mem_byte_enable <= '1;
            end else if (grant_b) begin
                onchip_mem_addr        <= b_addr;
                onchip_mem_byte_enable <= b_be;
                onchip_mem_write_data  <= b_wdata;
            end
        end
    end

    // One extra stage covers the bus register in front of the RAM latency
    mem_rd_tag_pipe #(
        .DEPTH (READ_LATENCY + 1)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue_read),
        .in_port   (issue_port),
        .out_valid (ret_valid),
        .out_port  (ret_port)
    );

    // Capture returning RAM data into the port that issued the read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= ret_valid && (ret_port == PORT_A);
            b_rvalid <= ret_valid && (ret_port == PORT_B);
            if (ret_valid && (ret_port == PORT_A)) begin
                a_rdata <= onchip_mem_readd_data;
            end
            if (ret_valid && (ret_port == PORT_B)) begin
                b_rdata <= onchip_mem_readd_data;
            end
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - directed and random checks of onchip_mem_arbiter against a scoreboard
module tb_onchip_mem_arbiter;
    import hdmi_mem_pkg::*;

    localparam int RL1     = 1;
    localparam int RL3     = 3;
    localparam int MAX_RUN = 4;
    localparam int WORDS   = 2048;

    typedef struct {
        logic          we;
        logic [10:0]   addr;
        logic [31:0]   be;
        logic [255:0]  data;
    } cmd_t;

    typedef struct {
        int            due;
        logic          port;
        logic [255:0]  data;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    logic a_req, b_req, b_we;
    logic [10:0]  a_addr, b_addr;
    logic [31:0]  b_be;
    logic [255:0] b_wdata;

    logic a_ready1, a_rvalid1, b_ready1, b_rvalid1;
    logic [255:0] a_rdata1, b_rdata1;
    logic m1_cs, m1_rd, m1_wr;
    logic [10:0] m1_addr;
    logic [31:0] m1_be;
    logic [255:0] m1_wdata;

    logic a_ready3, a_rvalid3, b_ready3, b_rvalid3;
    logic [255:0] a_rdata3, b_rdata3;
    logic m3_cs, m3_rd, m3_wr;
    logic [10:0] m3_addr;
    logic [31:0] m3_be;
    logic [255:0] m3_wdata;

    bit           ram_loaded;
    logic [255:0] ram1 [WORDS];
    logic [255:0] ram3 [WORDS];
    logic [255:0] ram_q1;
    logic [255:0] ram_q3 [RL3];

    logic [255:0] shadow [WORDS];
    resp_t q1[$];
    resp_t q3[$];
    cmd_t  a_cmd_q[$];
    cmd_t  b_cmd_q[$];
    int    b_acc_cyc[$];

    int cyc, n_checks, n_fails, streak, gap_pct;
    logic a_acc, b_acc, rst_nxt;
    logic prev_acc, prev_we;
    logic [10:0] prev_addr;
    logic [31:0] prev_be;
    logic [255:0] prev_wdata;
    logic [255:0] w;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.READ_LATENCY(RL1), .MAX_A_RUN(MAX_RUN)) u_dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_ready(a_ready1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_ready(b_ready1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
        .onchip_mem_chip_select(m1_cs), .onchip_mem_chip_read(m1_rd), .onchip_mem_write(m1_wr),
        .onchip_mem_addr(m1_addr), .onchip_mem_byte_enable(m1_be), .onchip_mem_write_data(m1_wdata),
        .onchip_mem_readd_data(ram_q1)
    );

    onchip_mem_arbiter #(.READ_LATENCY(RL3), .MAX_A_RUN(MAX_RUN)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_ready(a_ready3), .a_rvalid(a_rvalid3), .a_rdata(a_rdata3),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_ready(b_ready3), .b_rvalid(b_rvalid3), .b_rdata(b_rdata3),
        .onchip_mem_chip_select(m3_cs), .onchip_mem_chip_read(m3_rd), .onchip_mem_write(m3_wr),
        .onchip_mem_addr(m3_addr), .onchip_mem_byte_enable(m3_be), .onchip_mem_write_data(m3_wdata),
        .onchip_mem_readd_data(ram_q3[RL3-1])
    );

    function automatic logic [255:0] init_word(input int i);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = 32'(i * 40503 + k * 7919) ^ 32'h5A5A_0000;
        return v;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    function automatic cmd_t rd_cmd(input int addr);
        cmd_t c;
        c.we = 1'b0; c.addr = 11'(addr); c.be = 32'hFFFF_FFFF; c.data = 256'd0;
        return c;
    endfunction

    function automatic cmd_t wr_cmd(input int addr, input logic [31:0] be, input logic [255:0] data);
        cmd_t c;
        c.we = 1'b1; c.addr = 11'(addr); c.be = be; c.data = data;
        return c;
    endfunction

    // Behavioural RAMs behind each DUT: byte-enable writes, READ_LATENCY-cycle reads
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < WORDS; i++) begin
                ram1[i] <= init_word(i);
                ram3[i] <= init_word(i);
            end
            ram_loaded <= 1'b1;
        end else begin
            if (m1_cs && m1_wr)
                for (int b = 0; b < 32; b++) if (m1_be[b]) ram1[m1_addr][8*b +: 8] <= m1_wdata[8*b +: 8];
            if (m3_cs && m3_wr)
                for (int b = 0; b < 32; b++) if (m3_be[b]) ram3[m3_addr][8*b +: 8] <= m3_wdata[8*b +: 8];
        end
        ram_q1    <= ram1[m1_addr];
        ram_q3[0] <= ram3[m3_addr];
        for (int s = 1; s < RL3; s++) ram_q3[s] <= ram_q3[s-1];
    end

    task automatic check(input string tag, input logic [299:0] got, input logic [299:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_ret(input string tag, input logic av, input logic bv,
                             input logic [255:0] ad, input logic [255:0] bd,
                             input logic has, input resp_t r);
        logic ea, eb;
        ea = has && !r.port;
        eb = has && r.port;
        check({tag, "_rvalid"}, 300'({av, bv}), 300'({ea, eb}));
        if (ea) check({tag, "_a_rdata"}, 300'(ad), 300'(r.data));
        if (eb) check({tag, "_b_rdata"}, 300'(bd), 300'(r.data));
    endtask

    // Called at the falling edge: compare everything, then advance the reference model
    task automatic monitor();
        logic ea, eb, has1, has3;
        resp_t r1, r3;
        cmd_t c;
        ea = 1'b0;
        eb = 1'b0;
        if (!rst) begin
            if (a_req && b_req) begin
                if (streak == MAX_RUN) eb = 1'b1;
                else ea = 1'b1;
            end else begin
                ea = a_req;
                eb = b_req;
            end
        end
        check("ready", 300'({a_ready1, b_ready1, a_ready3, b_ready3}), 300'({ea, eb, ea, eb}));
        check("bus_strobe", 300'({m1_cs, m1_rd, m1_wr, m3_cs, m3_rd, m3_wr}),
              300'({2{prev_acc, prev_acc && !prev_we, prev_acc && prev_we}}));
        if (prev_acc) check("bus_cmd", 300'({m1_addr, m1_be, m3_addr, m3_be}), 300'({2{prev_addr, prev_be}}));
        if (prev_acc && prev_we) begin
            check("bus_wdata1", 300'(m1_wdata), 300'(prev_wdata));
            check("bus_wdata3", 300'(m3_wdata), 300'(prev_wdata));
        end

        has1 = 1'b0;
        has3 = 1'b0;
        r1 = '{0, 1'b0, 256'd0};
        r3 = '{0, 1'b0, 256'd0};
        if (q1.size() > 0) if (q1[0].due == cyc) begin has1 = 1'b1; r1 = q1.pop_front(); end
        if (q3.size() > 0) if (q3[0].due == cyc) begin has3 = 1'b1; r3 = q3.pop_front(); end
        check_ret("l1", a_rvalid1, b_rvalid1, a_rdata1, b_rdata1, has1, r1);
        check_ret("l3", a_rvalid3, b_rvalid3, a_rdata3, b_rdata3, has3, r3);

        a_acc = ea;
        b_acc = eb;
        prev_acc = ea || eb;
        if (ea) c = rd_cmd(int'(a_addr));
        else c = wr_cmd(int'(b_addr), b_be, b_wdata);
        if (eb) c.we = b_we;
        if (prev_acc) begin
            prev_we = c.we; prev_addr = c.addr; prev_be = c.be; prev_wdata = c.data;
            if (c.we) begin
                for (int b = 0; b < 32; b++) if (c.be[b]) shadow[c.addr][8*b +: 8] = c.data[8*b +: 8];
            end else begin
                q1.push_back('{cyc + 2 + RL1, eb, shadow[c.addr]});
                q3.push_back('{cyc + 2 + RL3, eb, shadow[c.addr]});
            end
        end
        if (eb) b_acc_cyc.push_back(cyc);
        if (ea && b_req) streak = (streak < MAX_RUN) ? streak + 1 : streak;
        else streak = 0;
    endtask

    task automatic cycle();
        cmd_t c;
        @(posedge clk);
        cyc++;
        #1;
        rst = rst_nxt;
        if (a_acc) a_req = 1'b0;
        if (b_acc) b_req = 1'b0;
        if (!a_req && a_cmd_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            c = a_cmd_q.pop_front();
            a_req = 1'b1; a_addr = c.addr;
        end
        if (!b_req && b_cmd_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            c = b_cmd_q.pop_front();
            b_req = 1'b1; b_we = c.we; b_addr = c.addr; b_be = c.be; b_wdata = c.data;
        end
        if (!a_req) a_addr = 11'($urandom);
        if (!b_req) begin
            b_we = 1'($urandom); b_addr = 11'($urandom); b_be = $urandom; b_wdata = rand256();
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((a_cmd_q.size() + b_cmd_q.size() + q1.size() + q3.size() > 0 || a_req || b_req) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_left", 300'(a_cmd_q.size() + b_cmd_q.size() + q1.size() + q3.size()), 300'(0));
        repeat (2) cycle();
    endtask

    initial begin
        rst = 1'b1; rst_nxt = 1'b1;
        a_req = 1'b0; a_addr = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_be = '0; b_wdata = '0;
        cyc = 0; n_checks = 0; n_fails = 0; streak = 0; gap_pct = 0;
        a_acc = 1'b0; b_acc = 1'b0;
        prev_acc = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_be = '0; prev_wdata = '0;
        for (int i = 0; i < WORDS; i++) shadow[i] = init_word(i);

        repeat (3) cycle();
        check("reset_out", 300'({a_rvalid1, b_rvalid1, m1_cs, m1_rd, m1_wr, m1_addr, m1_be, a_rvalid3, b_rvalid3}), 300'(0));
        check("reset_rdata", 300'(a_rdata1 | b_rdata1 | m1_wdata | a_rdata3), 300'(0));
        rst_nxt = 1'b0;

        // A-only streaming reads of words 0..7
        for (int i = 0; i < 8; i++) a_cmd_q.push_back(rd_cmd(i));
        drain(100);

        // Partial byte-enable write followed by read-back on port B
        b_cmd_q.push_back(wr_cmd(5, 32'h0000_000F, {32{8'hAA}}));
        b_cmd_q.push_back(rd_cmd(5));
        drain(100);
        w = init_word(5);
        check("be_merge", 300'(b_rdata1), 300'({w[255:32], 32'hAAAA_AAAA}));

        // Both ports saturated: starvation guard gives B every fifth slot
        b_acc_cyc.delete();
        for (int i = 0; i < 20; i++) a_cmd_q.push_back(rd_cmd(int'($urandom_range(63))));
        for (int i = 0; i < 4; i++) b_cmd_q.push_back(rd_cmd(64 + int'($urandom_range(63))));
        drain(200);
        for (int i = 1; i < 4; i++) check("b_spacing", 300'(b_acc_cyc[i] - b_acc_cyc[i-1]), 300'(5));

        // Interleaved A and B reads must return to their own ports
        a_cmd_q.push_back(rd_cmd(1));
        b_cmd_q.push_back(rd_cmd(2));
        drain(50);

        // Reset with two reads in flight
        a_cmd_q.push_back(rd_cmd(10));
        a_cmd_q.push_back(rd_cmd(11));
        repeat (3) cycle();
        #2;
        rst = 1'b1;
        rst_nxt = 1'b1;
        #1;
        check("rst_async", 300'({a_ready1, b_ready1, a_rvalid1, b_rvalid1, m1_cs, m1_rd, m1_wr, m1_addr, m1_be,
                                 a_rvalid3, b_rvalid3, m3_cs}), 300'(0));
        check("rst_rdata", 300'(a_rdata1 | b_rdata1 | a_rdata3 | m1_wdata), 300'(0));
        q1.delete(); q3.delete();
        prev_acc = 1'b0; streak = 0; a_acc = 1'b0; b_acc = 1'b0;
        repeat (3) cycle();
        rst_nxt = 1'b0;
        repeat (6) cycle();
        a_cmd_q.push_back(rd_cmd(10));
        drain(50);

        // Random mix on a small address window to provoke read-after-write
        gap_pct = 25;
        for (int i = 0; i < 200; i++) begin
            a_cmd_q.push_back(rd_cmd(int'($urandom_range(15))));
            if ($urandom_range(1) == 1) b_cmd_q.push_back(wr_cmd(int'($urandom_range(15)), $urandom, rand256()));
            else b_cmd_q.push_back(rd_cmd(int'($urandom_range(15))));
        end
        drain(4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Shares the single 256-bit on-chip pattern memory between two masters: port A, the fast pattern fetch path (read-only, bandwidth-critical, feeds HDMI output), and port B, the host pattern loader (read/write). It grants A with fixed priority, bounded by a starvation guard that forces a B grant after a run of A grants. It also drives the registered memory command bus and routes returned read data to the issuing port. It sits between the pattern-fetch/loader logic and the on-chip RAM.

## Interface
- READ_LATENCY, 1, memory cycles from command-on-bus to valid read data (1..4)
- MAX_A_RUN, 16, consecutive A grants allowed while B waits (1..255)
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- a_req  in  1  port A read request
- a_addr  in  11  port A word address
- a_ready  out  1  port A request accepted this cycle
- a_rvalid  out  1  port A read data valid
- a_rdata  out  256  port A read data
- b_req  in  1  port B request
- b_we  in  1  port B: 1 = write, 0 = read
- b_addr  in  11  port B word address
- b_be  in  32  port B byte enables (writes only)
- b_wdata  in  256  port B write data
- b_ready  out  1  port B request accepted this cycle
- b_rvalid  out  1  port B read data valid
- b_rdata  out  256  port B read data
- onchip_mem_chip_select  out  1  memory select
- onchip_mem_chip_read  out  1  memory read strobe
- onchip_mem_write  out  1  memory write strobe
- onchip_mem_addr  out  11  memory address
- onchip_mem_byte_enable  out  32  memory byte enables
- onchip_mem_write_data  out  256  memory write data
- onchip_mem_readd_data  in  256  memory read data

## Operation
- One command accepted per cycle max; a_ready and b_ready are never both 1.
- A request is accepted when req=1 and ready=1 in the same cycle; the requester holds req and payload stable until accepted.
- Grant rule, combinational from current inputs and run counter:
  - only A requesting -> grant A; only B requesting -> grant B.
  - both requesting -> grant A unless a_run == MAX_A_RUN, then grant B.
- a_run (8-bit): increments on each A grant while b_req=1. Clears to 0 on any B grant and on any cycle with b_req=0. Saturates at MAX_A_RUN.
- Accepted command registered onto the memory bus the next cycle: chip_select=1, chip_read=~we, write=we, addr/byte_enable/write_data from winner. Port A commands force byte_enable=all-ones, write=0. Bus idle cycle: all strobes 0, addr/data hold last value.
- Return routing: a READ_LATENCY+1 deep shift register of {valid, port} tracks each read on the bus. Writes push valid=0.
- When the tag emerges, onchip_mem_readd_data is registered into the tagged port's rdata and that rvalid pulses for 1 cycle. The other port's rdata holds.
- Read data returns in issue order; no reordering, no backpressure on rvalid.
- Reset: all strobes 0, addr 0, byte_enable 0, write_data 0, a_ready/b_ready 0 while rst=1, rvalid 0, rdata 0, a_run 0, tag pipe cleared. In-flight reads at reset are discarded and never return.

## Timing
- Accept at cycle T -> command on memory bus at T+1.
- Read: rvalid/rdata at T+2+READ_LATENCY (default T+3).
- Write: memory written at T+1; no response.
- Full throughput: back-to-back accepts every cycle, in any A/B mix.
- Write at T followed by read of same address at T+1 returns the new data; the RAM is read-after-write safe across cycles.

## Structure
- Shared package hdmi_mem_pkg: MEM_AW=11, MEM_DW=256, MEM_BEW=32, port tag enum {PORT_A, PORT_B}.
- One natural sub-module: mem_rd_tag_pipe, the {valid,port} delay line of parameter depth.

## Test plan
- A-only reads, a_req held 1 for addresses 0..7 -> a_ready every cycle, a_rvalid on 8 consecutive cycles starting 3 cycles after first accept, data matching preloaded RAM words 0..7.
- B write of addr 5 with b_be=32'h0000_000F and data all-0xAA, then B read of addr 5 -> bytes 0..3 = 0xAA, others unchanged, b_rvalid only (a_rvalid stays 0).
- A and B both requesting continuously, MAX_A_RUN=4 -> grant pattern AAAAB repeating; b_ready exactly every 5th cycle.
- Interleaved A read addr 1 and B read addr 2 on consecutive cycles -> a_rvalid with word 1, next cycle b_rvalid with word 2; no cross-routing.
- READ_LATENCY=3 build, single A read -> a_rvalid at T+5.
- rst asserted with two reads in flight -> all outputs 0 immediately, no rvalid after release, first post-reset A read returns correct data.
